// File: rtl/scfifo_wr_arbiter_if.sv
// Requester/FIFO write-side bundle for scfifo_wr_arbiter.
// The arbiter uses the slave modport; requesters and the FIFO sit on the master side.
interface scfifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 64
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_data_count;
  logic                          grant_active;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;
  logic                          timeout_evt;

  modport master (
    output req_valid, req_data, req_last, fifo_wr_full, fifo_data_count,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id, timeout_evt
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_wr_full, fifo_data_count,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id, timeout_evt
  );
endinterface

// File: rtl/scfifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port between NUM_REQ requesters.
// Define SCFIFO_ARB_RESERVE_EN to grant only when a full MAX_BURST of FIFO space is free.
module scfifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 64,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 32
) (
  input logic               clk,
  input logic               rst,
  scfifo_wr_arbiter_if.slave bus
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     rr_ptr;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                timeout_evt;

  logic                hit;
  logic [ID_W-1:0]     winner;
  logic                admit;
  logic [NUM_REQ-1:0]  ready;
  logic                cur_valid;
  logic                cur_last;
  logic                accept;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    hit    = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!hit && bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        hit    = 1'b1;
        winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

`ifdef SCFIFO_ARB_RESERVE_EN
  logic [CNT_W-1:0] free_space;
  assign free_space = CNT_W'(FIFO_DEPTH) - bus.fifo_data_count;
  assign admit      = (free_space >= CNT_W'(MAX_BURST));
`else
  logic unused_count;
  assign unused_count = ^bus.fifo_data_count;
  assign admit        = 1'b1;
`endif

  // Ready is gated by rst so the beat in flight during a reset cycle is not written.
  always_comb begin
    ready = '0;
    if (state == GRANT && !rst)
      ready[grant_id] = !bus.fifo_wr_full;
  end

  assign cur_valid = bus.req_valid[grant_id];
  assign cur_last  = bus.req_last[grant_id];
  assign accept    = cur_valid & ready[grant_id];

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_wr_data = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_active = (state == GRANT);
  assign bus.grant_id     = grant_id;
  assign bus.timeout_evt  = timeout_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (hit && admit) begin
            grant_id <= winner;
            rr_ptr   <= winner;
            beat_cnt <= '0;
            idle_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // An accepted beat wins over a coincident timeout.
          if (accept) begin
            idle_cnt <= '0;
            beat_cnt <= beat_cnt + 1'b1;
            if (cur_last || beat_cnt == BEAT_W'(MAX_BURST - 1))
              state <= IDLE;
          end else if (!cur_valid) begin
            if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
              state       <= IDLE;
              timeout_evt <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
